mem_access: RTL

//  MEM stage of the 5-stage pipeline, directly upstream of write_back.
//  - Takes the EX/MEM bundle and runs loads/stores on a req/ack data-memory bus.
//  - Extracts and extends load data.
//  - Registers the MEM/WB bundle whose wb_alu/wb_mo/wb_m2reg drive write_back's r_alu/m_o/m2reg.
//  - Stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on a req/ack data-memory bus, extends load data
// and registers the MEM/WB bundle, stalling upstream while a transaction is outstanding.
module mem_access #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [4:0]  ex_rn,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_b,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_rn,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mo,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Copy of the accepted memory instruction; upstream moves on once it is captured.
    logic        lat_wreg_reg;
    logic        lat_m2reg_reg;
    logic        lat_unsigned_reg;
    logic [4:0]  lat_rn_reg;
    logic [31:0] lat_alu_reg;
    logic [1:0]  lat_ea_reg;
    logic [1:0]  lat_size_reg;

    logic        is_mem;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;
    logic [3:0]  byte_be;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = dm_rdata[8*gi +: 8];
            assign byte_be[gi] = (ex_alu[1:0] == 2'(gi));
        end
    endgenerate

    assign mem_stall = (state_reg == BUSY);

    always_comb begin
        is_mem     = ex_m2reg | ex_wmem;
        is_word    = ex_size[1];
        is_half    = (ex_size == 2'b01);
        misaligned = (is_word && (ex_alu[1:0] != 2'b00)) || (is_half && ex_alu[0]);
        if (is_word) begin
            be_next    = 4'b1111;
            wdata_next = ex_b;
        end else if (is_half) begin
            be_next    = ex_alu[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{ex_b[15:0]}};
        end else begin
            be_next    = byte_be;
            wdata_next = {4{ex_b[7:0]}};
        end
    end

    // Lane selection uses the latched address bits since ex_* may already hold the next bundle.
    always_comb begin
        sel_byte = rd_byte[lat_ea_reg];
        sel_half = lat_ea_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (lat_size_reg)
            2'b00:   load_data = {{24{~lat_unsigned_reg & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{~lat_unsigned_reg & sel_half[15]}}, sel_half};
            default: load_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            lat_wreg_reg     <= 1'b0;
            lat_m2reg_reg    <= 1'b0;
            lat_unsigned_reg <= 1'b0;
            lat_rn_reg       <= '0;
            lat_alu_reg      <= '0;
            lat_ea_reg       <= '0;
            lat_size_reg     <= '0;
            dm_req           <= 1'b0;
            dm_we            <= 1'b0;
            dm_addr          <= '0;
            dm_be            <= '0;
            dm_wdata         <= '0;
            wb_valid         <= 1'b0;
            wb_wreg          <= 1'b0;
            wb_m2reg         <= 1'b0;
            wb_rn            <= '0;
            wb_alu           <= '0;
            wb_mo            <= '0;
            misalign         <= 1'b0;
            bus_err          <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (!ex_valid) begin
                        wb_valid <= 1'b0;
                        wb_wreg  <= 1'b0;
                    end else if (!is_mem || misaligned) begin
                        wb_valid <= 1'b1;
                        wb_wreg  <= ex_wreg & ~is_mem;
                        wb_m2reg <= ex_m2reg;
                        wb_rn    <= ex_rn;
                        wb_alu   <= ex_alu;
                        wb_mo    <= '0;
                        misalign <= is_mem;
                    end else begin
                        wb_valid         <= 1'b0;
                        wb_wreg          <= 1'b0;
                        lat_wreg_reg     <= ex_wreg;
                        lat_m2reg_reg    <= ex_m2reg;
                        lat_unsigned_reg <= ex_unsigned;
                        lat_rn_reg       <= ex_rn;
                        lat_alu_reg      <= ex_alu;
                        lat_ea_reg       <= ex_alu[1:0];
                        lat_size_reg     <= ex_size;
                        dm_req           <= 1'b1;
                        dm_we            <= ~ex_m2reg;
                        dm_addr          <= {ex_alu[31:2], 2'b00};
                        dm_be            <= be_next;
                        dm_wdata         <= wdata_next;
                        state_reg        <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (dm_ack || cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg <= IDLE;
                        dm_req    <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_wreg   <= dm_ack & lat_m2reg_reg & lat_wreg_reg;
                        wb_m2reg  <= lat_m2reg_reg;
                        wb_rn     <= lat_rn_reg;
                        wb_alu    <= lat_alu_reg;
                        wb_mo     <= (dm_ack && lat_m2reg_reg) ? load_data : '0;
                        bus_err   <= ~dm_ack;
                    end else begin
                        wb_valid <= 1'b0;
                        wb_wreg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
